// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and emits one `key` strobe with a 4-bit {row,col} symbol per press.
// Optional build macro: KEYPAD_MULTI_REJECT_EN (reject samples with 2+ rows low).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key,
    output logic [3:0] code,
    output logic       busy
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [SLOT_W-1:0] slot;
    logic [1:0]        col_idx;
    logic [1:0]        cand_row;
    logic [1:0]        cand_col;
    logic [CNT_W-1:0]  deb_cnt;
    logic [CNT_W-1:0]  rel_cnt;

    logic              sample;
    logic [3:0]        row_low;
    logic              row_hit;
    logic [1:0]        row_idx;
    logic              row_valid;
    logic              rel_hold;

    // Active-low one-hot column drive for a column index
    function automatic logic [3:0] col_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (clr) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Free-running slot counter; the last slot cycle is the sample point
    always_ff @(posedge clk) begin
        if (clr) begin
            slot <= '0;
        end else begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end
    end

    assign sample = (slot == SLOT_LAST);

    // Row decode: any low row is a hit, lowest-index low row wins
    always_comb begin
        row_low = ~row_sync;
        row_hit = |row_low;
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) row_idx = 2'(i);
        end
    end

`ifdef KEYPAD_MULTI_REJECT_EN
    logic row_multi;

    // Two or more rows low is ambiguous: no hit, and freezes release counting
    always_comb begin
        row_multi = (row_low & (row_low - 4'd1)) != 4'd0;
        row_valid = row_hit && !row_multi;
        rel_hold  = row_multi;
    end
`else
    // Any low row is a usable hit; release counting never pauses
    always_comb begin
        row_valid = row_hit;
        rel_hold  = 1'b0;
    end
`endif

    // Scan / debounce / held FSM with registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_SCAN;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            deb_cnt  <= '0;
            rel_cnt  <= '0;
            key      <= 1'b0;
            code     <= 4'h0;
            busy     <= 1'b0;
        end else begin
            key <= 1'b0;
            if (sample) begin
                unique case (state)
                    ST_SCAN: begin
                        if (row_valid) begin
                            cand_row <= row_idx;
                            cand_col <= col_idx;
                            deb_cnt  <= CNT_W'(1);
                            busy     <= 1'b1;
                            if (DEBOUNCE_CNT == 1) begin
                                key     <= 1'b1;
                                code    <= {row_idx, col_idx};
                                rel_cnt <= '0;
                                state   <= ST_HELD;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col     <= col_onehot(col_idx + 2'd1);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row_valid && (row_idx == cand_row)) begin
                            if (deb_cnt == CNT_LAST) begin
                                key     <= 1'b1;
                                code    <= {cand_row, cand_col};
                                deb_cnt <= '0;
                                rel_cnt <= '0;
                                state   <= ST_HELD;
                            end else begin
                                deb_cnt <= deb_cnt + CNT_W'(1);
                            end
                        end else begin
                            deb_cnt <= '0;
                            col_idx <= col_idx + 2'd1;
                            col     <= col_onehot(col_idx + 2'd1);
                            busy    <= 1'b0;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (!rel_hold) begin
                            if (row_sync[cand_row]) begin
                                if (rel_cnt == CNT_LAST) begin
                                    rel_cnt <= '0;
                                    col_idx <= 2'd0;
                                    col     <= 4'b1110;
                                    busy    <= 1'b0;
                                    state   <= ST_SCAN;
                                end else begin
                                    rel_cnt <= rel_cnt + CNT_W'(1);
                                end
                            end else begin
                                rel_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed keypad presses; a sample-level
// reference model predicts strobes into a scoreboard drained by a monitor.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
`ifdef KEYPAD_MULTI_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    localparam int M_SCAN = 0;
    localparam int M_CONF = 1;
    localparam int M_HELD = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key;
    logic [3:0]  code;
    logic        busy;
    logic [15:0] keys = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_key = 0;
    logic [3:0]  sb[$];

    // Reference model state (one step per scan sample)
    int          m_mode;
    int          m_col;
    int          m_r;
    int          m_c;
    int          m_cnt;
    int          m_rel;
    logic [3:0]  m_code;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk  (clk),
        .clr  (clr),
        .row  (row),
        .col  (col),
        .key  (key),
        .code (code),
        .busy (busy)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_SCAN;
        m_col  = 0;
        m_cnt  = 0;
        m_rel  = 0;
        m_code = 4'h0;
        sb.delete();
    endtask

    task automatic model_accept();
        m_code = {2'(m_r), 2'(m_c)};
        sb.push_back(m_code);
        m_mode = M_HELD;
        m_rel  = 0;
    endtask

    // One sample: which rows of the model's current column are pressed
    task automatic model_sample();
        logic [3:0] low;
        int         nlow;
        int         first;
        bit         usable;
        low   = '0;
        for (int r = 0; r < 4; r++) low[r] = keys[r*4+m_col];
        nlow  = $countones(low);
        first = -1;
        for (int r = 3; r >= 0; r--) if (low[r]) first = r;
        usable = (nlow == 1) || (!REJ && nlow > 1);
        case (m_mode)
            M_SCAN: begin
                if (usable) begin
                    m_r = first; m_c = m_col; m_cnt = 1;
                    if (m_cnt == int'(DEB)) model_accept();
                    else m_mode = M_CONF;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
            M_CONF: begin
                if (usable && first == m_r) begin
                    m_cnt++;
                    if (m_cnt == int'(DEB)) model_accept();
                end else begin
                    m_cnt  = 0;
                    m_col  = (m_col + 1) % 4;
                    m_mode = M_SCAN;
                end
            end
            default: begin
                if (!(REJ && nlow > 1)) begin
                    if (!low[m_r]) begin
                        m_rel++;
                        if (m_rel == int'(DEB)) begin
                            m_mode = M_SCAN;
                            m_col  = 0;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
            end
        endcase
    endtask

    // Drive one slot of keys from a negedge, step the model at the sample edge
    task automatic run_slot(input logic [15:0] k);
        keys = k;
        repeat (SCAN_DIV) @(posedge clk);
        model_sample();
        #1;
        check("col", col, ~(4'b0001 << m_col));
        check("busy", {3'b0, busy}, {3'b0, (m_mode != M_SCAN)});
        check("code", code, m_code);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {3'b0, busy}, 4'h0);
        check("rst_col", col, 4'b1110);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic align_col1();
        for (int i = 0; i < 8 && m_col != 1; i++) run_slot('0);
    endtask

    task automatic drained(input string name);
        check_int(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every strobe pops one predicted symbol
    initial begin
        logic prev_key;
        prev_key = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (key === 1'b1) begin
                n_key++;
                if (prev_key) begin
                    n_cmp++; n_bad++;
                    $display("FAIL key_double: key high on consecutive cycles at %0t", $time);
                end
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL strobe_unexpected: got code %h expected no strobe at %0t", code, $time);
                end else begin
                    check("strobe_code", code, sb.pop_front());
                end
            end
            prev_key = key;
        end
    end

    initial begin
        int         k0;
        int         sel;
        int         hold;
        logic [15:0] mask;
        model_reset();

        // Reset state and idle rotation
        clr  = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_key", {3'b0, key}, 4'h0);
        check("rst_code", code, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        clr = 1'b0;
        run_slot('0); check("rot1", col, 4'b1101);
        run_slot('0); check("rot2", col, 4'b1011);
        run_slot('0); check("rot3", col, 4'b0111);
        run_slot('0); check("rot0", col, 4'b1110);

        // Clean press of row2/col1
        align_col1();
        k0 = n_key;
        repeat (10) run_slot(16'h0200);
        check("clean_code", code, 4'h9);
        check("clean_busy", {3'b0, busy}, 4'h1);
        repeat (5) run_slot('0);
        check("clean_idle", {3'b0, busy}, 4'h0);
        check_int("clean_strobes", n_key - k0, 1);
        drained("clean_drain");

        // Bouncy press
        align_col1();
        k0 = n_key;
        run_slot(16'h0200);
        run_slot('0);
        repeat (12) run_slot(16'h0200);
        repeat (5) run_slot('0);
        check_int("bounce_strobes", n_key - k0, 1);
        drained("bounce_drain");

        // Long hold with a release glitch
        align_col1();
        k0 = n_key;
        repeat (50) run_slot(16'h0200);
        run_slot('0);
        run_slot(16'h0200);
        repeat (3) run_slot('0);
        check("held_resume", col, 4'b1110);
        check("held_idle", {3'b0, busy}, 4'h0);
        repeat (2) run_slot('0);
        check_int("held_strobes", n_key - k0, 1);
        drained("held_drain");

        // Row0 and row3 together in col3
        k0 = n_key;
        repeat (10) run_slot(16'h8008);
`ifndef KEYPAD_MULTI_REJECT_EN
        check("multi_code", code, 4'h3);
`endif
        repeat (5) run_slot('0);
        check_int("multi_strobes", n_key - k0, REJ ? 0 : 1);
        drained("multi_drain");

        // Reset mid-debounce with the key held
        align_col1();
        k0 = n_key;
        repeat (2) run_slot(16'h0200);
        keys = 16'h0200;
        do_reset();
        check_int("rst_mid_strobes", n_key - k0, 0);
        repeat (10) run_slot(16'h0200);
        repeat (5) run_slot('0);
        check_int("rst_after_strobes", n_key - k0, 1);
        drained("rst_drain");

        // Randomized presses, occasional resets
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) mask = '0;
            else if (sel < 8) mask = 16'(1) << $urandom_range(0, 15);
            else mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            hold = $urandom_range(1, 14);
            repeat (hold) run_slot(mask);
            if ($urandom_range(0, 19) == 0) begin
                keys = mask;
                do_reset();
            end
        end
        repeat (8) run_slot('0);
        drained("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
